bin_frac_div: RTL

- Sequential restoring divider for unsigned binary fractions; it is the inverse of the team's shift-add fraction multiplier and uses the same start/done handshake.
- Operands are N-bit fractions 0.xxxxxxx (value = word/2^N). Result is an N-bit fractional quotient plus remainder, one quotient bit per clock.
- Used to normalise multiplier products back to operand scale and to check multiplier results (a*b/b == a).

---
 rtl/bin_frac_div.sv | 115 +++++++++++
 1 files changed

// File: rtl/bin_frac_div.sv
// Sequential restoring divider for unsigned N-bit binary fractions.
// Start/done handshake; one quotient bit per clock, MSB first.
module bin_frac_div #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         ovf,
  output logic         dz
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   part_rem, part_rem_nxt;
  logic [N-1:0]   div_q, div_nxt;
  logic [N-1:0]   quo_nxt, rem_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           done_nxt, ovf_nxt, dz_nxt;
  logic [N:0]     dbl;
  logic           fits;
  logic [N-1:0]   step_rem;

  // Partial remainder stays below the divisor, so N bits hold it; only the
  // doubled value needs the extra bit.
  assign dbl      = {part_rem, 1'b0};
  assign fits     = (dbl >= {1'b0, div_q});
  assign step_rem = fits ? (dbl[N-1:0] - div_q) : dbl[N-1:0];
  assign busy     = (state == CALC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      part_rem  <= '0;
      div_q     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      state     <= state_nxt;
      part_rem  <= part_rem_nxt;
      div_q     <= div_nxt;
      cnt       <= cnt_nxt;
      quotient  <= quo_nxt;
      remainder <= rem_nxt;
      done      <= done_nxt;
      ovf       <= ovf_nxt;
      dz        <= dz_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    part_rem_nxt = part_rem;
    div_nxt      = div_q;
    cnt_nxt      = cnt;
    quo_nxt      = quotient;
    rem_nxt      = remainder;
    done_nxt     = 1'b0;
    ovf_nxt      = ovf;
    dz_nxt       = dz;
    unique case (state)
      IDLE: begin
        if (start) begin
          div_nxt = b;
          if (b == '0) begin
            dz_nxt   = 1'b1;
            ovf_nxt  = 1'b0;
            quo_nxt  = '1;
            rem_nxt  = '0;
            done_nxt = 1'b1;
          end else if (a >= b) begin
            dz_nxt   = 1'b0;
            ovf_nxt  = 1'b1;
            quo_nxt  = '1;
            rem_nxt  = '0;
            done_nxt = 1'b1;
          end else begin
            dz_nxt       = 1'b0;
            ovf_nxt      = 1'b0;
            part_rem_nxt = a;
            quo_nxt      = '0;
            rem_nxt      = '0;
            cnt_nxt      = CW'(N);
            state_nxt    = CALC;
          end
        end
      end
      CALC: begin
        part_rem_nxt = step_rem;
        quo_nxt      = {quotient[N-2:0], fits};
        cnt_nxt      = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          rem_nxt   = step_rem;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
